// File: rtl/fm_radio_pkg.sv
// rtl/fm_radio_pkg.sv - shared constants, CORDIC tables and types for the FM radio blocks
//
// Contents:
//   QUANT_BITS    fractional bits of baseband and I/Q samples (Q10)
//   CORDIC_GUARD  extra fractional bits carried inside the CORDIC datapath
//   ATAN[i]       atan(2^-i) as a phase word, 2^32 = one full turn
//   CORDIC_KINV   reciprocal of the CORDIC gain
//   cordic_x0()   pre-scaled CORDIC start vector for a given envelope amplitude
//   fm_state_t    modulator control states
package fm_radio_pkg;

    localparam int QUANT_BITS   = 10;
    localparam int CORDIC_GUARD = 8;
    localparam int ATAN_LEN     = 24;

    // round(atan(2^-i) / (2*pi) * 2^32)
    localparam logic [31:0] ATAN [ATAN_LEN] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051
    };

    localparam real CORDIC_KINV = 0.6072529350;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        ROT   = 2'd2,
        OUT   = 2'd3
    } fm_state_t;

    // Start vector x such that the CORDIC gain brings it back to amp,
    // with the guard bits included. Evaluated at elaboration only.
    function automatic logic signed [31:0] cordic_x0(input int amp);
        real v;
        v = real'(amp) * CORDIC_KINV * real'(1 << CORDIC_GUARD);
        return 32'($rtoi(v + 0.5));
    endfunction

endpackage

// File: rtl/cordic_rotator.sv
// rtl/cordic_rotator.sv - iterative rotation-mode CORDIC with quadrant fix-up
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle pulse: load x0/y0/z0/quad and begin rotating
//   x0, y0              start vector, CORDIC_GUARD fractional guard bits
//   z0                  residual angle in phase-word units, must lie in [0, 90 deg)
//   quad                quadrant (phase[31:30]) applied after rotation
//   done                high in the cycle of the last step; results valid next cycle
//   real_out, imag_out  rounded, quadrant-corrected result; held until next done
module cordic_rotator
    import fm_radio_pkg::*;
#(
    parameter int ITER = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [31:0] x0,
    input  logic signed [31:0] y0,
    input  logic signed [31:0] z0,
    input  logic [1:0]         quad,
    output logic               done,
    output logic signed [31:0] real_out,
    output logic signed [31:0] imag_out
);

    localparam logic [4:0]         LAST_STEP  = 5'(ITER - 1);
    localparam logic signed [31:0] ROUND_HALF = 32'sd1 <<< (CORDIC_GUARD - 1);

    logic signed [31:0] x_r, y_r, z_r;
    logic [1:0]         quad_r;
    logic [4:0]         step;
    logic               busy;

    logic               dir_pos;
    logic signed [31:0] x_sh, y_sh, angle;
    logic signed [31:0] x_nx, y_nx, z_nx;
    logic signed [31:0] x_rnd, y_rnd;

    always_comb begin
        dir_pos = ~z_r[31];
        x_sh    = x_r >>> step;
        y_sh    = y_r >>> step;
        angle   = ATAN[step];
        x_nx    = dir_pos ? (x_r - y_sh)  : (x_r + y_sh);
        y_nx    = dir_pos ? (y_r + x_sh)  : (y_r - x_sh);
        z_nx    = dir_pos ? (z_r - angle) : (z_r + angle);
        // Round the final step's vector straight into Q10 so the result is
        // registered on the same edge the last rotation completes.
        x_rnd   = (x_nx + ROUND_HALF) >>> CORDIC_GUARD;
        y_rnd   = (y_nx + ROUND_HALF) >>> CORDIC_GUARD;
        done    = busy && (step == LAST_STEP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_r      <= '0;
            y_r      <= '0;
            z_r      <= '0;
            quad_r   <= '0;
            step     <= '0;
            busy     <= 1'b0;
            real_out <= '0;
            imag_out <= '0;
        end else if (start) begin
            x_r    <= x0;
            y_r    <= y0;
            z_r    <= z0;
            quad_r <= quad;
            step   <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            x_r  <= x_nx;
            y_r  <= y_nx;
            z_r  <= z_nx;
            step <= step + 5'd1;
            if (step == LAST_STEP) begin
                busy <= 1'b0;
                // Rotate the first-quadrant result by quad * 90 degrees.
                case (quad_r)
                    2'd0: begin real_out <= x_rnd;  imag_out <= y_rnd;  end
                    2'd1: begin real_out <= -y_rnd; imag_out <= x_rnd;  end
                    2'd2: begin real_out <= -x_rnd; imag_out <= -y_rnd; end
                    default: begin real_out <= y_rnd; imag_out <= -x_rnd; end
                endcase
            end
        end
    end

endmodule

// File: rtl/fm_modulate.sv
// rtl/fm_modulate.sv - FM modulator: baseband samples to constant-envelope I/Q
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_empty, in_dout    first-word-fall-through input FIFO (signed Q10 samples)
//   in_rd_en             pop strobe, one cycle per sample
//   out_full             shared full flag of the I and Q output FIFOs
//   out_wr_en            push strobe for real_out/imag_out
//   real_out, imag_out   signed Q10 I/Q sample, stable while waiting on out_full
module fm_modulate
    import fm_radio_pkg::*;
#(
    parameter logic [31:0] KF   = 32'h0010_0000,
    parameter int          AMP  = 1024,
    parameter int          ITER = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_empty,
    input  logic [31:0]        in_dout,
    output logic               in_rd_en,
    input  logic               out_full,
    output logic               out_wr_en,
    output logic signed [31:0] real_out,
    output logic signed [31:0] imag_out
);

    localparam logic signed [31:0] X0 = cordic_x0(AMP);

    fm_state_t          state, state_next;
    logic signed [31:0] sample_r;
    logic [31:0]        phase_acc;
    logic [31:0]        phase_inc;
    logic [31:0]        phase_next;
    logic               cordic_start;
    logic               cordic_done;

    // Only the low word of sample*KF is needed; it is identical for signed and
    // unsigned multiplication, and dropping the high word is the intended wrap.
    assign phase_inc  = $unsigned(sample_r) * KF;
    assign phase_next = phase_acc + phase_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sample_r  <= '0;
            phase_acc <= '0;
        end else begin
            state <= state_next;
            if (in_rd_en) begin
                sample_r <= in_dout;
            end
            if (state == PHASE) begin
                phase_acc <= phase_next;
            end
        end
    end

    always_comb begin
        state_next   = state;
        in_rd_en     = 1'b0;
        out_wr_en    = 1'b0;
        cordic_start = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (!in_empty) begin
                        in_rd_en   = 1'b1;
                        state_next = PHASE;
                    end
                end
                PHASE: begin
                    cordic_start = 1'b1;
                    state_next   = ROT;
                end
                ROT: begin
                    if (cordic_done) begin
                        state_next = OUT;
                    end
                end
                OUT: begin
                    if (!out_full) begin
                        out_wr_en  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    cordic_rotator #(
        .ITER (ITER)
    ) u_cordic (
        .clk      (clk),
        .reset    (reset),
        .start    (cordic_start),
        .x0       (X0),
        .y0       (32'sd0),
        .z0       ({2'b00, phase_next[29:0]}),
        .quad     (phase_next[31:30]),
        .done     (cordic_done),
        .real_out (real_out),
        .imag_out (imag_out)
    );

endmodule

// File: tb/tb_fm_modulate.sv
// tb/tb_fm_modulate.sv - self-checking bench for fm_modulate against a cos/sin phase model
module tb_fm_modulate;

    localparam int          ITER = 16;
    localparam int          AMP  = 1024;
    localparam logic [31:0] KF_A = 32'h0010_0000;
    localparam logic [31:0] KF_B = 32'h0008_0000;
    localparam real         PI   = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               reset;
    logic               a_in_empty, a_in_rd_en, a_out_full, a_out_wr_en;
    logic [31:0]        a_in_dout;
    logic signed [31:0] a_real, a_imag;
    logic               b_in_empty, b_in_rd_en, b_out_full, b_out_wr_en;
    logic [31:0]        b_in_dout;
    logic signed [31:0] b_real, b_imag;

    always #5 clk = ~clk;

    fm_modulate #(.KF(KF_A), .AMP(AMP), .ITER(ITER)) dut_a (
        .clk(clk), .reset(reset),
        .in_empty(a_in_empty), .in_dout(a_in_dout), .in_rd_en(a_in_rd_en),
        .out_full(a_out_full), .out_wr_en(a_out_wr_en),
        .real_out(a_real), .imag_out(a_imag)
    );

    fm_modulate #(.KF(KF_B), .AMP(AMP), .ITER(ITER)) dut_b (
        .clk(clk), .reset(reset),
        .in_empty(b_in_empty), .in_dout(b_in_dout), .in_rd_en(b_in_rd_en),
        .out_full(b_out_full), .out_wr_en(b_out_wr_en),
        .real_out(b_real), .imag_out(b_imag)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          in_q[$];
    int          exp_re[$];
    int          exp_im[$];
    logic [31:0] model_phase = '0;
    int          pops_a = 0, pushes_a = 0;
    int          last_re = 0, last_im = 0;
    bit          rand_mode = 0, force_full = 0;
    int          b_pending = 0, b_rd_cyc = 0, b_wr_cyc = 0, b_pushes = 0;
    int          b_re = 0, b_im = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input longint exp, input int tol);
        bit ok;
        ok = (obs - exp <= longint'(tol)) && (exp - obs <= longint'(tol));
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    function automatic int golden(input logic [31:0] ph, input bit want_sin);
        real ang;
        ang = 2.0 * PI * real'(ph) / 4294967296.0;
        if (want_sin) return $rtoi($floor(real'(AMP) * $sin(ang) + 0.5));
        return $rtoi($floor(real'(AMP) * $cos(ang) + 0.5));
    endfunction

    // Phase advances by sample*KF modulo one turn; each pop yields one expected pair.
    task automatic model_pop(input int s);
        longint      p;
        logic [63:0] pv;
        p  = longint'(s) * longint'(KF_A);
        pv = p;
        model_phase = model_phase + pv[31:0];
        exp_re.push_back(golden(model_phase, 1'b0));
        exp_im.push_back(golden(model_phase, 1'b1));
    endtask

    task automatic cycle();
        longint e2;
        int     er, ei;
        a_in_empty = (in_q.size() == 0) || (rand_mode && $urandom_range(0, 99) < 30);
        a_in_dout  = (in_q.size() != 0) ? in_q[0] : 32'd0;
        a_out_full = force_full || (rand_mode && $urandom_range(0, 99) < 30);
        b_in_empty = (b_pending == 0);
        b_in_dout  = 32'd1024;
        b_out_full = 1'b0;
        #1;
        if (a_in_rd_en) begin
            pops_a++;
            model_pop(in_q.pop_front());
        end
        if (a_out_wr_en) begin
            pushes_a++;
            last_re = a_real;
            last_im = a_imag;
            if (exp_re.size() == 0) begin
                check("push_without_pop", 1, 0);
            end else begin
                er = exp_re.pop_front();
                ei = exp_im.pop_front();
                check_near("real_out", a_real, er, 2);
                check_near("imag_out", a_imag, ei, 2);
                e2 = longint'(a_real) * a_real + longint'(a_imag) * a_imag;
                check("envelope_1024pm3", (e2 >= 1021 * 1021 && e2 <= 1027 * 1027), 1);
            end
        end
        if (b_in_rd_en) begin
            b_pending--;
            b_rd_cyc = cyc;
        end
        if (b_out_wr_en) begin
            b_pushes++;
            b_wr_cyc = cyc;
            b_re = b_real;
            b_im = b_imag;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_q.delete();
        exp_re.delete();
        exp_im.delete();
        model_phase = '0;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    task automatic run_until_pushes(input int target, input int budget);
        int n;
        n = 0;
        while (pushes_a < target && n < budget) begin
            cycle();
            n++;
        end
        if (pushes_a < target) check("push_timeout", pushes_a, target);
    endtask

    task automatic run_until_pop(input int target, input int budget);
        int n;
        n = 0;
        while (pops_a < target && n < budget) begin
            cycle();
            n++;
        end
        if (pops_a < target) check("pop_timeout", pops_a, target);
    endtask

    initial begin
        int w0, p0, hold_re, hold_im, n;
        bit stable;

        // Reset state, with data offered on both inputs so the gating is visible.
        reset = 1'b1;
        a_in_empty = 1'b0; a_in_dout = 32'd5; a_out_full = 1'b0;
        b_in_empty = 1'b0; b_in_dout = 32'd5; b_out_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_rd_en", a_in_rd_en, 0);
        check("reset_out_wr_en", a_out_wr_en, 0);
        check("reset_real_out", a_real, 0);
        check("reset_imag_out", a_imag, 0);
        check("reset_phase_acc", dut_a.phase_acc, 0);
        check("reset_b_in_rd_en", b_in_rd_en, 0);
        do_reset();

        // Four quarter turns come back to zero phase.
        repeat (4) in_q.push_back(1024);
        run_until_pushes(pushes_a + 4, 200);
        check("quarter_turns_last_real", last_re, 1024);
        check("phase_wrapped_to_zero", dut_a.phase_acc, 0);

        // Zero samples hold the phase; -1.0 rotates clockwise.
        do_reset();
        repeat (3) in_q.push_back(0);
        in_q.push_back(-1024);
        run_until_pushes(pushes_a + 4, 200);
        check_near("neg_sample_real", last_re, 0, 2);
        check_near("neg_sample_imag", last_im, -1024, 2);

        // Half gain: 45 degrees and exact pop-to-push latency.
        b_pending = 1;
        n = 0;
        while (b_pushes == 0 && n < 100) begin cycle(); n++; end
        check("kf_half_push_seen", b_pushes, 1);
        check("latency_rd_to_wr", b_wr_cyc - b_rd_cyc, ITER + 2);
        check_near("kf_half_real", b_re, 724, 2);
        check_near("kf_half_imag", b_im, 724, 2);

        // Back-pressure in OUT: no push, stable outputs, no further pop.
        force_full = 1'b1;
        p0 = pops_a;
        in_q.push_back(1024);
        run_until_pop(p0 + 1, 20);
        repeat (ITER + 2) cycle();
        hold_re = a_real;
        hold_im = a_imag;
        in_q.push_back(512);
        w0 = pushes_a;
        p0 = pops_a;
        stable = 1'b1;
        repeat (50) begin
            cycle();
            if (a_real !== hold_re || a_imag !== hold_im) stable = 1'b0;
        end
        check("full_no_push", pushes_a, w0);
        check("full_no_pop", pops_a, p0);
        check("full_outputs_stable", stable, 1);
        force_full = 1'b0;
        run_until_pushes(w0 + 1, 5);
        check("release_push_real", last_re, hold_re);
        check("release_push_imag", last_im, hold_im);
        run_until_pushes(w0 + 2, 100);
        check("release_single_push_then_next", pushes_a, w0 + 2);

        // Reset during rotation discards the sample and clears the phase.
        p0 = pops_a;
        in_q.push_back(1024);
        run_until_pop(p0 + 1, 20);
        repeat (5) cycle();
        w0 = pushes_a;
        do_reset();
        repeat (30) cycle();
        check("reset_mid_rot_no_push", pushes_a, w0);
        check("reset_mid_rot_phase", dut_a.phase_acc, 0);
        in_q.push_back(1024);
        run_until_pushes(w0 + 1, 100);
        check_near("after_reset_real", last_re, 0, 2);
        check_near("after_reset_imag", last_im, 1024, 2);

        // Randomized stream with random empty/full.
        rand_mode = 1'b1;
        w0 = pushes_a;
        p0 = pops_a;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) in_q.push_back(int'($urandom()));
            else in_q.push_back(int'($urandom_range(0, 8192)) - 4096);
        end
        run_until_pushes(w0 + 1000, 60000);
        rand_mode = 1'b0;
        check("random_pop_count", pops_a - p0, 1000);
        check("random_push_eq_pop", pushes_a - w0, pops_a - p0);
        check("random_expect_drained", exp_re.size(), 0);
        check("random_phase_acc", dut_a.phase_acc, model_phase);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
